alu_hs: RTL

- Parametrised successor to the handshake adder: a BITS-wide, clocked, handshake-driven arithmetic unit.
- Supports ADD, SUB, AND and an iterative unsigned MUL, and reports carry/borrow and overflow flags.
- Operands are captured on rising input-enable edges and the result is presented under OE.
- OE is held until both enables return low, then the unit re-arms. It sits as a shared compute slave behind a sequencer or bench.

---
 rtl/alu_hs_pkg.sv | 24 ++
 rtl/alu_hs_mul.sv | 54 +++++
 rtl/alu_hs.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_hs_pkg.sv
// Shared opcode constants, FSM state type and flag helper for the handshake ALU.
package alu_hs_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_AND = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Signed overflow from sign bits only. For SUB the B sign is effectively
   // inverted, so overflow needs operands of opposite sign.
   function automatic logic sgn_ovf(input logic a_msb, input logic b_msb,
                                    input logic y_msb, input logic is_sub);
      logic same;
      same = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
      return same && (y_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_hs_mul.sv
// Unsigned shift-add multiplier. The START cycle already folds in bit 0 of B,
// so the remaining BITS-1 bits take BITS-1 further cycles and DONE pulses on
// the cycle the product becomes final.
module alu_hs_mul #(
   parameter int BITS = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [BITS-1:0]   A,
   input  logic [BITS-1:0]   B,
   output logic              DONE,
   output logic [2*BITS-1:0] P
);

   localparam int CW = $clog2(BITS) + 1;

   logic [2*BITS-1:0] mcand;
   logic [BITS-1:0]   mplier;
   logic [CW-1:0]     cnt;
   logic              run;

   // Load operands on START, then add the shifted multiplicand per set bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         run    <= 1'b0;
         DONE   <= 1'b0;
         P      <= '0;
      end else begin
         DONE <= 1'b0;
         if (START) begin
            mcand  <= {{BITS{1'b0}}, A} << 1;
            mplier <= B >> 1;
            P      <= B[0] ? {{BITS{1'b0}}, A} : '0;
            cnt    <= CW'(1);
            run    <= 1'b1;
         end else if (run) begin
            if (mplier[0])
               P <= P + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(BITS - 1)) begin
               run  <= 1'b0;
               DONE <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_hs.sv
// Handshake-driven ALU: operands latched on rising IEA/IEB edges, result held
// under OE until both enables drop, then the unit re-arms.
module alu_hs
   import alu_hs_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [BITS-1:0] A,
   input  logic [BITS-1:0] B,
   input  logic [1:0]      OP,
   input  logic            IEA,
   input  logic            IEB,
   output logic [BITS-1:0] Y,
   output logic [BITS-1:0] YH,
   output logic            CO,
   output logic            V,
   output logic            OE,
   output logic            BUSY
);

   state_t            state;
   logic [BITS-1:0]   a_q, b_q;
   logic [1:0]        op_q;
   logic              gota, gotb;
   logic              prev_a, prev_b;

   logic              iea_edge, ieb_edge, go;
   logic [BITS-1:0]   a_nxt, b_nxt;
   logic [1:0]        op_nxt;

   logic [BITS:0]     sum, dif;
   logic [BITS-1:0]   r_y;
   logic              r_co, r_v;

   logic              mul_done;
   logic [2*BITS-1:0] mul_p;

   // Edge detect plus the operand values that will be latched this cycle; the
   // multiplier must see them on the same edge that leaves IDLE.
   always_comb begin
      iea_edge = IEA & ~prev_a;
      ieb_edge = IEB & ~prev_b;
      a_nxt    = iea_edge ? A  : a_q;
      b_nxt    = ieb_edge ? B  : b_q;
      op_nxt   = ieb_edge ? OP : op_q;
      go       = (state == IDLE) && (gota || iea_edge) && (gotb || ieb_edge);
   end

   // Single-cycle ops computed from latched operands.
   always_comb begin
      sum  = {1'b0, a_q} + {1'b0, b_q};
      dif  = {1'b0, a_q} - {1'b0, b_q};
      r_y  = '0;
      r_co = 1'b0;
      r_v  = 1'b0;
      case (op_q)
         OP_ADD: begin
            r_y  = sum[BITS-1:0];
            r_co = sum[BITS];
            r_v  = sgn_ovf(a_q[BITS-1], b_q[BITS-1], sum[BITS-1], 1'b0);
         end
         OP_SUB: begin
            r_y  = dif[BITS-1:0];
            r_co = dif[BITS];
            r_v  = sgn_ovf(a_q[BITS-1], b_q[BITS-1], dif[BITS-1], 1'b1);
         end
         OP_AND:  r_y = a_q & b_q;
         default: r_y = '0;
      endcase
   end

   alu_hs_mul #(.BITS(BITS)) u_mul (
      .CLK   (CLK),
      .RST   (RST),
      .START (go && (op_nxt == OP_MUL)),
      .A     (a_nxt),
      .B     (b_nxt),
      .DONE  (mul_done),
      .P     (mul_p)
   );

   // Handshake FSM with registered outputs. Enable history resets high so a
   // level already asserted at reset release is not mistaken for an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         gota   <= 1'b0;
         gotb   <= 1'b0;
         prev_a <= 1'b1;
         prev_b <= 1'b1;
         Y      <= '0;
         YH     <= '0;
         CO     <= 1'b0;
         V      <= 1'b0;
         OE     <= 1'b0;
         BUSY   <= 1'b0;
      end else begin
         prev_a <= IEA;
         prev_b <= IEB;
         case (state)
            IDLE: begin
               if (iea_edge) begin
                  a_q  <= A;
                  gota <= 1'b1;
               end
               if (ieb_edge) begin
                  b_q  <= B;
                  op_q <= OP;
                  gotb <= 1'b1;
               end
               if (go) begin
                  state <= CALC;
                  BUSY  <= 1'b1;
               end
            end
            CALC: begin
               if (op_q != OP_MUL) begin
                  Y     <= r_y;
                  YH    <= '0;
                  CO    <= r_co;
                  V     <= r_v;
                  OE    <= 1'b1;
                  state <= DONE;
               end else if (mul_done) begin
                  Y     <= mul_p[BITS-1:0];
                  YH    <= mul_p[2*BITS-1:BITS];
                  CO    <= 1'b0;
                  V     <= |mul_p[2*BITS-1:BITS];
                  OE    <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!IEA && !IEB) begin
                  OE    <= 1'b0;
                  gota  <= 1'b0;
                  gotb  <= 1'b0;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
               OE    <= 1'b0;
            end
         endcase
      end
   end

endmodule
